// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding, byte sizing helper and tuser bit positions for div_fixed_iter
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  localparam int DBZ_BIT = 0;
  localparam int OVF_BIT = 1;
  function automatic int byte_ceil(input int bits);
    return (bits + 7) / 8;
  endfunction
endpackage

// File: rtl/div_radix2_core.sv
// div_radix2_core: restoring shift-subtract divider, one quotient bit per cycle over A_W+SH cycles
//   aclk, aresetn  clock, async active-low reset
//   start          load |a|, |b| and begin (must not be raised while running)
//   a_mag, b_mag   unsigned operand magnitudes; numerator is a_mag << SH
//   q_mag          quotient magnitude, valid once done has been seen
//   done           high during the final iteration cycle
module div_radix2_core #(
  parameter int A_W = 64,
  parameter int B_W = 64,
  parameter int SH = 17
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [A_W-1:0]       a_mag,
  input  logic [B_W-1:0]       b_mag,
  output logic [A_W+SH-1:0]    q_mag,
  output logic                 done
);
  localparam int N = A_W + SH;
  localparam int CNT_W = $clog2(N + 1);
  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [B_W-1:0]   rem;
  logic [B_W-1:0]   b_q;
  logic [N-1:0]     num;
  logic [B_W:0]     trial;
  logic [B_W:0]     diff;
  // numerator bits shift out of num's top while quotient bits shift in at the bottom
  assign trial = {rem, num[N-1]};
  assign diff = trial - {1'b0, b_q};
  assign done = active && cnt == CNT_W'(1);
  assign q_mag = num;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      active <= 1'b0;
      cnt <= '0;
      rem <= '0;
      b_q <= '0;
      num <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt <= CNT_W'(N);
      rem <= '0;
      b_q <= b_mag;
      num <= N'(a_mag) << SH;
    end else if (active) begin
      rem <= diff[B_W] ? trial[B_W-1:0] : diff[B_W-1:0];
      num <= {num[N-2:0], ~diff[B_W]};
      cnt <= cnt - CNT_W'(1);
      active <= cnt != CNT_W'(1);
    end
endmodule

// File: rtl/div_fixed_iter.sv
// div_fixed_iter: signed fixed-point divider Q = (dividend << FRAC_W) / divisor with AXI-Stream channels
//   aclk, aresetn        clock, async active-low reset
//   s_axis_dividend_*    signed dividend and user tag into a one-entry latch
//   s_axis_divisor_*     signed divisor into a one-entry latch
//   m_axis_dout_*        quotient sign-extended to whole bytes, tuser = {tag, ovf, dbz}
//   busy                 FSM not idle
module div_fixed_iter
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W = 64,
  parameter int FRAC_W = 17,
  parameter int QUOT_W = 81,
  parameter int USER_W = 8,
  parameter int ROUND_MODE = 0
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            s_axis_dividend_tvalid,
  output logic                            s_axis_dividend_tready,
  input  logic [DIVIDEND_W-1:0]           s_axis_dividend_tdata,
  input  logic [USER_W-1:0]               s_axis_dividend_tuser,
  input  logic                            s_axis_divisor_tvalid,
  output logic                            s_axis_divisor_tready,
  input  logic [DIVISOR_W-1:0]            s_axis_divisor_tdata,
  output logic                            m_axis_dout_tvalid,
  input  logic                            m_axis_dout_tready,
  output logic [8*byte_ceil(QUOT_W)-1:0]  m_axis_dout_tdata,
  output logic [USER_W+1:0]               m_axis_dout_tuser,
  output logic                            busy
);
  localparam int SH = FRAC_W + ROUND_MODE;
  localparam int N = DIVIDEND_W + SH;
  localparam int MW = N + 1;
  localparam int CW = (MW > QUOT_W ? MW : QUOT_W) + 1;
  localparam int OUT_W = 8 * byte_ceil(QUOT_W);
  localparam logic [CW-1:0] LIM_N = CW'(1) << (QUOT_W - 1);
  localparam logic [CW-1:0] LIM_P = LIM_N - CW'(1);
  localparam logic [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};
  div_state_e              state, state_d;
  logic                    dvd_v, dvs_v;
  logic [DIVIDEND_W-1:0]   dvd_d, a_mag;
  logic [USER_W-1:0]       dvd_u, tag_q;
  logic [DIVISOR_W-1:0]    dvs_d, b_mag;
  logic                    take, bz, start, done, load;
  logic                    sign_q, neg_q, dbz_q, res_ovf, ovf;
  logic [N-1:0]            q_mag;
  logic [MW-1:0]           mag;
  logic [CW-1:0]           mag_w;
  logic [QUOT_W-1:0]       q_trunc, q_sgn, q_fix, res_q;
  assign s_axis_dividend_tready = !dvd_v;
  assign s_axis_divisor_tready = !dvs_v;
  assign busy = state != IDLE;
  assign take = state == IDLE && dvd_v && dvs_v;
  assign bz = dvs_d == '0;
  assign start = take && !bz;
  assign load = state == DONE && (!m_axis_dout_tvalid || m_axis_dout_tready);
  // unsigned magnitudes: the most-negative value negates to itself, read unsigned it is exact
  assign a_mag = dvd_d[DIVIDEND_W-1] ? -dvd_d : dvd_d;
  assign b_mag = dvs_d[DIVISOR_W-1] ? -dvs_d : dvs_d;
  div_radix2_core #(.A_W(DIVIDEND_W), .B_W(DIVISOR_W), .SH(SH)) u_core (
    .aclk(aclk),
    .aresetn(aresetn),
    .start(start),
    .a_mag(a_mag),
    .b_mag(b_mag),
    .q_mag(q_mag),
    .done(done)
  );
  // with rounding the core produces one extra fraction bit which is folded back in here
  assign mag = ROUND_MODE != 0 ? MW'(q_mag >> 1) + MW'(q_mag[0]) : MW'(q_mag);
  assign mag_w = CW'(mag);
  assign ovf = !dbz_q && (sign_q ? mag_w > LIM_N : mag_w > LIM_P);
  assign q_trunc = QUOT_W'(mag_w);
  assign q_sgn = sign_q ? -q_trunc : q_trunc;
  assign q_fix = dbz_q ? (neg_q ? Q_MIN : Q_MAX) : ovf ? (sign_q ? Q_MIN : Q_MAX) : q_sgn;
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: state_d = take ? (bz ? FIX : CALC) : IDLE;
      CALC: state_d = done ? FIX : CALC;
      FIX:  state_d = DONE;
      DONE: state_d = load ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      dvd_v <= 1'b0;
      dvd_d <= '0;
      dvd_u <= '0;
      dvs_v <= 1'b0;
      dvs_d <= '0;
      sign_q <= 1'b0;
      neg_q <= 1'b0;
      dbz_q <= 1'b0;
      tag_q <= '0;
      res_q <= '0;
      res_ovf <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata <= '0;
      m_axis_dout_tuser <= '0;
    end else begin
      if (s_axis_dividend_tvalid && !dvd_v) begin
        dvd_v <= 1'b1;
        dvd_d <= s_axis_dividend_tdata;
        dvd_u <= s_axis_dividend_tuser;
      end else if (take) dvd_v <= 1'b0;
      if (s_axis_divisor_tvalid && !dvs_v) begin
        dvs_v <= 1'b1;
        dvs_d <= s_axis_divisor_tdata;
      end else if (take) dvs_v <= 1'b0;
      if (take) begin
        sign_q <= dvd_d[DIVIDEND_W-1] ^ dvs_d[DIVISOR_W-1];
        neg_q <= dvd_d[DIVIDEND_W-1];
        dbz_q <= bz;
        tag_q <= dvd_u;
      end
      if (state == FIX) begin
        res_q <= q_fix;
        res_ovf <= ovf;
      end
      if (load) begin
        m_axis_dout_tvalid <= 1'b1;
        m_axis_dout_tdata <= OUT_W'($signed(res_q));
        m_axis_dout_tuser[USER_W+1:2] <= tag_q;
        m_axis_dout_tuser[OVF_BIT] <= res_ovf;
        m_axis_dout_tuser[DBZ_BIT] <= dbz_q;
      end else if (m_axis_dout_tready) m_axis_dout_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_div_fixed_iter.sv
// tb_div_fixed_iter: scoreboard bench for three divider variants (truncate, round, 24-bit saturating)
module tb_div_fixed_iter;
  import div_pkg::*;
  localparam int NI = 3;
  typedef struct {logic [87:0] q; logic [9:0] u; int lat; int t0;} exp_t;
  logic aclk = 1'b0;
  logic aresetn;
  logic av [NI], ar [NI], bv [NI], br [NI], ov [NI], ordy [NI], bsy [NI];
  logic [63:0] ad [NI], bd [NI];
  logic [7:0] au [NI];
  logic [87:0] od0, od1;
  logic [23:0] od2;
  logic [9:0] ou [NI];
  logic [NI-1:0] hold, rnd;
  exp_t sb [NI][$];
  int cyc = 0, tests = 0, errors = 0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk)
    for (int k = 0; k < NI; k++) ordy[k] <= hold[k] ? 1'b0 : rnd[k] ? ($urandom_range(0, 3) != 0) : 1'b1;
  div_fixed_iter u0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_dividend_tvalid(av[0]), .s_axis_dividend_tready(ar[0]),
    .s_axis_dividend_tdata(ad[0]), .s_axis_dividend_tuser(au[0]),
    .s_axis_divisor_tvalid(bv[0]), .s_axis_divisor_tready(br[0]), .s_axis_divisor_tdata(bd[0]),
    .m_axis_dout_tvalid(ov[0]), .m_axis_dout_tready(ordy[0]),
    .m_axis_dout_tdata(od0), .m_axis_dout_tuser(ou[0]), .busy(bsy[0])
  );
  div_fixed_iter #(.ROUND_MODE(1)) u1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_dividend_tvalid(av[1]), .s_axis_dividend_tready(ar[1]),
    .s_axis_dividend_tdata(ad[1]), .s_axis_dividend_tuser(au[1]),
    .s_axis_divisor_tvalid(bv[1]), .s_axis_divisor_tready(br[1]), .s_axis_divisor_tdata(bd[1]),
    .m_axis_dout_tvalid(ov[1]), .m_axis_dout_tready(ordy[1]),
    .m_axis_dout_tdata(od1), .m_axis_dout_tuser(ou[1]), .busy(bsy[1])
  );
  div_fixed_iter #(.QUOT_W(24)) u2 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_dividend_tvalid(av[2]), .s_axis_dividend_tready(ar[2]),
    .s_axis_dividend_tdata(ad[2]), .s_axis_dividend_tuser(au[2]),
    .s_axis_divisor_tvalid(bv[2]), .s_axis_divisor_tready(br[2]), .s_axis_divisor_tdata(bd[2]),
    .m_axis_dout_tvalid(ov[2]), .m_axis_dout_tready(ordy[2]),
    .m_axis_dout_tdata(od2), .m_axis_dout_tuser(ou[2]), .busy(bsy[2])
  );
  function automatic logic [87:0] dout(input int k);
    return k == 0 ? od0 : k == 1 ? od1 : {{64{od2[23]}}, od2};
  endfunction
  task automatic check(input string n, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  // reference: exact rational quotient, rounded/clamped with plain wide arithmetic
  function automatic void ref_div(input int k, input logic [63:0] a, input logic [63:0] b,
                                  output logic [87:0] q, output logic [1:0] fl);
    logic [63:0] an, bn;
    logic [127:0] am, bm, qm, lim, v;
    logic s;
    int qw;
    qw = (k == 2) ? 24 : 81;
    an = a[63] ? -a : a;
    bn = b[63] ? -b : b;
    am = {64'd0, an};
    bm = {64'd0, bn};
    lim = 128'd1 << (qw - 1);
    s = a[63] ^ b[63];
    fl = '0;
    if (bm == 0) begin
      fl[DBZ_BIT] = 1'b1;
      v = a[63] ? -lim : lim - 1;
    end else begin
      qm = (k == 1) ? ((am << 18) + bm) / (bm << 1) : (am << 17) / bm;
      if (!s && qm >= lim) begin fl[OVF_BIT] = 1'b1; v = lim - 1; end
      else if (s && qm > lim) begin fl[OVF_BIT] = 1'b1; v = -lim; end
      else v = s ? -qm : qm;
    end
    q = v[87:0];
  endfunction
  task automatic put_a(input int k, input logic [63:0] a, input logic [7:0] t);
    av[k] = 1'b1; ad[k] = a; au[k] = t;
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (ar[k]) break;
      if (n > 5000) begin tests++; errors++; $display("FAIL dividend_accept_timeout dut=%0d", k); break; end
    end
    @(posedge aclk); #1 av[k] = 1'b0;
  endtask
  task automatic put_b(input int k, input logic [63:0] b);
    bv[k] = 1'b1; bd[k] = b;
    for (int n = 0; ; n++) begin
      @(negedge aclk);
      if (br[k]) break;
      if (n > 5000) begin tests++; errors++; $display("FAIL divisor_accept_timeout dut=%0d", k); break; end
    end
    @(posedge aclk); #1 bv[k] = 1'b0;
  endtask
  task automatic put_pair(input int k, input logic [63:0] a, input logic [63:0] b, input logic [7:0] t,
                          input bit bfirst, input int gap, input int lat);
    exp_t e;
    logic [1:0] fl;
    if (bfirst) begin
      put_b(k, b);
      repeat (gap) @(posedge aclk);
      #1 put_a(k, a, t);
    end else begin
      put_a(k, a, t);
      put_b(k, b);
    end
    ref_div(k, a, b, e.q, fl);
    e.u = {t, fl};
    e.lat = lat;
    e.t0 = cyc;
    sb[k].push_back(e);
  endtask
  task automatic drain();
    for (int n = 0; n < 4000; n++) begin
      if (sb[0].size() + sb[1].size() + sb[2].size() == 0) return;
      @(posedge aclk); #1;
    end
    tests++; errors++;
    $display("FAIL drain_timeout pending=%0d/%0d/%0d", sb[0].size(), sb[1].size(), sb[2].size());
  endtask
  for (genvar g = 0; g < NI; g++) begin : mon
    logic seen = 1'b0, stab = 1'b1;
    int first = 0;
    logic [87:0] hd;
    logic [9:0] hu;
    exp_t e;
    always @(negedge aclk)
      if (!aresetn) seen = 1'b0;
      else if (ov[g]) begin
        if (!seen) begin
          seen = 1'b1; stab = 1'b1; first = cyc; hd = dout(g); hu = ou[g];
        end else if (dout(g) !== hd || ou[g] !== hu) stab = 1'b0;
        if (ordy[g]) begin
          seen = 1'b0;
          if (sb[g].size() == 0) begin
            tests++; errors++;
            $display("FAIL unexpected_output dut=%0d got=%h", g, dout(g));
          end else begin
            e = sb[g].pop_front();
            check($sformatf("dout_q%0d", g), dout(g), e.q);
            check($sformatf("dout_user%0d", g), ou[g], e.u);
            check($sformatf("dout_stable%0d", g), stab, 1'b1);
            if (e.lat >= 0) check($sformatf("latency%0d", g), first - e.t0, e.lat);
          end
        end
      end
  end
  initial begin
    logic [63:0] a, b;
    aresetn = 1'b0; hold = '0; rnd = '0;
    for (int k = 0; k < NI; k++) begin av[k] = 0; bv[k] = 0; ad[k] = 0; bd[k] = 0; au[k] = 0; end
    repeat (3) @(posedge aclk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_tvalid", ov[k], 1'b0);
      check("rst_a_tready", ar[k], 1'b1);
      check("rst_b_tready", br[k], 1'b1);
      check("rst_busy", bsy[k], 1'b0);
      check("rst_tdata", dout(k), 88'd0);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    put_pair(0, 64'd1, 64'd2, 8'h11, 0, 0, 84);
    drain();
    put_pair(0, 64'd1, 64'd3, 8'h12, 1, 2, 84);
    put_pair(1, 64'd1, 64'd3, 8'h13, 0, 0, 85);
    drain();
    put_pair(1, -64'd1, 64'd3, 8'h14, 0, 0, 85);
    put_pair(2, 64'd1 << 40, 64'd1, 8'h15, 0, 0, 84);
    drain();
    put_pair(2, -(64'd1 << 40), 64'd1, 8'h16, 0, 0, 84);
    put_pair(0, 64'd5, 64'd0, 8'h17, 0, 0, 3);
    drain();
    put_pair(0, -64'd5, 64'd0, 8'h18, 1, 0, 3);
    drain();
    put_pair(0, 64'h8000_0000_0000_0000, 64'd1, 8'h19, 0, 0, -1);
    put_pair(0, 64'h8000_0000_0000_0000, -64'd1, 8'h1a, 0, 0, -1);
    put_pair(0, 64'd0, -64'd9, 8'h1b, 0, 0, -1);
    drain();
    hold[0] = 1'b1;
    put_pair(0, -64'd100, 64'd7, 8'h31, 1, 10, 84);
    put_pair(0, 64'd12345, -64'd17, 8'h32, 0, 0, -1);
    put_pair(0, 64'h7fff_ffff_ffff_ffff, 64'd3, 8'h33, 0, 0, -1);
    repeat (200) @(posedge aclk);
    #1;
    check("stall_tvalid", ov[0], 1'b1);
    check("stall_a_tready", ar[0], 1'b0);
    check("stall_b_tready", br[0], 1'b0);
    hold[0] = 1'b0;
    drain();
    for (int k = 0; k < NI; k++) begin
      rnd[k] = 1'b1;
      for (int i = 0; i < 15; i++) begin
        a = {$urandom, $urandom};
        a = $signed(a) >>> $urandom_range(0, 63);
        b = {$urandom, $urandom};
        b = $signed(b) >>> $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) b = '0;
        put_pair(k, a, b, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 5), -1);
      end
      drain();
      rnd[k] = 1'b0;
    end
    hold[0] = 1'b1;
    put_pair(0, 64'd9, 64'd4, 8'h41, 0, 0, -1);
    repeat (90) @(posedge aclk);
    #1 put_pair(0, 64'd3, 64'd5, 8'h42, 0, 0, -1);
    repeat (20) @(posedge aclk);
    #1;
    check("pre_rst_tvalid", ov[0], 1'b1);
    check("pre_rst_busy", bsy[0], 1'b1);
    aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", ov[0], 1'b0);
    check("rst_mid_busy", bsy[0], 1'b0);
    for (int k = 0; k < NI; k++) sb[k].delete();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    hold[0] = 1'b0;
    check("post_rst_a_tready", ar[0], 1'b1);
    check("post_rst_b_tready", br[0], 1'b1);
    put_pair(0, 64'd7, -64'd2, 8'h43, 0, 0, 84);
    drain();
    repeat (5) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
